gen_sequencer: RTL

Parametrised run controller for N_GEN word generators (fibonacci, timer, and later sources) feeding a shared write buffer. It edge-detects start, stop and update requests and grants exactly one generator at a time. It forwards that generator's words to the buffer write port, with back-pressure from buffer_full. It drains to buffer_empty before returning to idle, and gates programme (clock-rate) updates so they occur only while idle. It sits in the top level between the input controls, the generators and the wrapper/dcm.

---
 rtl/gen_sequencer_pkg.sv | 14 +
 rtl/edge_detector.sv | 20 ++
 rtl/gen_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gen_sequencer_pkg.sv
// gen_sequencer shared types: FSM state encoding and width.
// Imported by the run controller and its bench.
package gen_sequencer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector for one level request.
// Ports: clock, reset (async high), din level in, rise one-cycle edge.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) prev <= 1'b0;
        else       prev <= din;
    end

    // Combinational so the FSM acts on the first edge that samples din high.
    assign rise = din & ~prev;

endmodule

// File: rtl/gen_sequencer.sv
// Run controller: grants one of N_GEN generators to the write buffer.
// Ports: start/stop/update requests, generator words in, buffer
// write port out, run statistics, state, sel and programme out.
module gen_sequencer
    import gen_sequencer_pkg::*;
#(
    parameter  int N_GEN  = 2,
    parameter  int DATA_W = 16,
    parameter  int PROG_W = 3,
    parameter  int CNT_W  = 16,
    localparam int SEL_W  = (N_GEN > 1) ? $clog2(N_GEN) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_GEN-1:0]        start,
    input  logic                    stop,
    input  logic                    update,
    input  logic [PROG_W-1:0]       prog_in,
    input  logic [N_GEN-1:0]        gen_valid,
    input  logic [N_GEN*DATA_W-1:0] gen_data,
    input  logic                    buffer_full,
    input  logic                    buffer_empty,
    output logic [N_GEN-1:0]        gen_en,
    output logic                    wr_en,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    parity,
    output logic [CNT_W-1:0]        word_cnt,
    output logic [SEL_W-1:0]        sel,
    output logic [STATE_W-1:0]      state,
    output logic [PROG_W-1:0]       prog_out,
    output logic                    update_pulse
);

    logic [N_GEN-1:0]  start_rise;
    logic              stop_rise;
    logic              upd_rise;

    for (genvar g = 0; g < N_GEN; g++) begin : g_start_ed
        edge_detector u_ed (
            .clock (clock),
            .reset (reset),
            .din   (start[g]),
            .rise  (start_rise[g])
        );
    end

    edge_detector u_stop_ed (
        .clock (clock),
        .reset (reset),
        .din   (stop),
        .rise  (stop_rise)
    );

    edge_detector u_upd_ed (
        .clock (clock),
        .reset (reset),
        .din   (update),
        .rise  (upd_rise)
    );

    logic [DATA_W-1:0] words [N_GEN];

    for (genvar g = 0; g < N_GEN; g++) begin : g_words
        assign words[g] = gen_data[g*DATA_W +: DATA_W];
    end

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  first_sel;
    logic              start_any;
    logic [CNT_W-1:0]  cnt_q;
    logic              par_q;
    logic [PROG_W-1:0] prog_q;
    logic              pulse_q;
    logic              run;

    // Fixed priority: lowest index wins, so scan downward.
    always_comb begin
        first_sel = '0;
        for (int i = N_GEN - 1; i >= 0; i--) begin
            if (start_rise[i]) first_sel = SEL_W'(i);
        end
    end

    assign start_any = |start_rise;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_any) begin
                    state_d = S_RUN;
                    sel_d   = first_sel;
                end
            end
            S_RUN: begin
                if (stop_rise)        state_d = S_DRAIN;
                else if (buffer_full) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (stop_rise)         state_d = S_DRAIN;
                else if (!buffer_full) state_d = S_RUN;
            end
            S_DRAIN: begin
                if (buffer_empty) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign run = (state_q == S_RUN);

    always_comb begin
        gen_en = '0;
        for (int i = 0; i < N_GEN; i++) begin
            gen_en[i] = run & (sel_q == SEL_W'(i)) & ~buffer_full;
        end
    end

    assign wr_en   = run & gen_valid[sel_q] & ~buffer_full;
    assign wr_data = wr_en ? words[sel_q] : '0;

    // Statistics restart with the run; wr_en only occurs in RUN,
    // so the clear and an increment never coincide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            par_q <= 1'b0;
        end else if (state_q == S_IDLE && start_any) begin
            cnt_q <= '0;
            par_q <= 1'b0;
        end else if (wr_en) begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            par_q <= par_q ^ (^wr_data);
        end
    end

    // Programme changes only while idle; other rises are dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prog_q  <= '0;
            pulse_q <= 1'b0;
        end else if (upd_rise && state_q == S_IDLE) begin
            prog_q  <= prog_in;
            pulse_q <= 1'b1;
        end else begin
            pulse_q <= 1'b0;
        end
    end

    assign parity       = par_q;
    assign word_cnt     = cnt_q;
    assign sel          = sel_q;
    assign state        = state_q;
    assign prog_out     = prog_q;
    assign update_pulse = pulse_q;

endmodule
